mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 6 +
 rtl/mem_array.sv | 17 +
 rtl/mem_responder.sv | 101 ++++++++++
 tb/tb_mem_responder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and RAM bus widths for mem_responder
package mem_pkg;
    localparam int RAM_DW = 32;
    localparam int RAM_AW = 64;
    typedef enum logic [1:0] {IDLE, BUSY, DONE, WAIT_REL} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port DEPTH x 32 storage, synchronous write, registered read
module mem_array import mem_pkg::*; #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [RAM_DW-1:0]        wd,
    output logic [RAM_DW-1:0]        rd
);
    logic [RAM_DW-1:0] mem [DEPTH];
    // write on request, read register always tracks the presented address
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wd;
        rd <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency handshake RAM responder; MEM_RESPONDER_RANGE_CHECK_EN flags addresses >= DEPTH
module mem_responder import mem_pkg::*; #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_txs,
    input  logic              ram_re,
    input  logic              ram_we,
    input  logic [RAM_AW-1:0] ram_addr,
    input  logic [RAM_DW-1:0] ram_wd,
    output logic              ram_txe,
    output logic              ram_err,
    output logic [RAM_DW-1:0] ram_out
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [IW-1:0] addr_q, addr_d, mem_addr;
    logic [RAM_DW-1:0] wd_q, wd_d, out_d, rd_data;
    logic we_q, we_d, bad_q, bad_d, txe_d, err_d, mem_we, oob;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    assign oob = |ram_addr[RAM_AW-1:IW];
`else
    logic unused_hi;
    assign unused_hi = ^ram_addr[RAM_AW-1:IW];
    assign oob = 1'b0;
`endif
    // present the incoming address while idle so read data is ready by the access edge
    assign mem_addr = (state == IDLE) ? ram_addr[IW-1:0] : addr_q;
    mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .we   (mem_we && rst_n),
        .addr (mem_addr),
        .wd   (wd_q),
        .rd   (rd_data)
    );
    // next-state, capture and access decisions
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        wd_d    = wd_q;
        we_d    = we_q;
        bad_d   = bad_q;
        txe_d   = ram_txe;
        err_d   = ram_err;
        out_d   = ram_out;
        mem_we  = 1'b0;
        case (state)
            IDLE: if (ram_txs && !ram_txe) begin
                state_d = BUSY;
                cnt_d   = CW'(LATENCY - 1);
                addr_d  = ram_addr[IW-1:0];
                wd_d    = ram_wd;
                we_d    = ram_we;
                bad_d   = (ram_re == ram_we) || oob;
            end
            BUSY: if (!ram_txs) state_d = WAIT_REL;
            else if (cnt == '0) begin
                state_d = DONE;
                txe_d   = 1'b1;
                err_d   = bad_q;
                out_d   = (bad_q || we_q) ? '0 : rd_data;
                mem_we  = !bad_q && we_q;
            end else cnt_d = cnt - 1'b1;
            DONE: if (!ram_txs) begin
                state_d = IDLE;
                txe_d   = 1'b0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            ram_txe <= 1'b0;
            ram_err <= 1'b0;
            ram_out <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            ram_txe <= txe_d;
            ram_err <= err_d;
            ram_out <= out_d;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random transactions checked against a word-array model
module tb_mem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    logic clk = 1'b0, rst_n = 1'b0, ram_txs = 1'b0, ram_re = 1'b0, ram_we = 1'b0;
    logic [63:0] ram_addr = '0;
    logic [31:0] ram_wd = '0, ram_out;
    logic ram_txe, ram_err;
    int checks = 0, errors = 0;
    logic [31:0] model [DEPTH];
    bit written [DEPTH];

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .ram_txs(ram_txs), .ram_re(ram_re), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_txe(ram_txe), .ram_err(ram_err), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic re, input logic we, input logic [63:0] addr, input logic [31:0] wd, input int hold);
        logic oob, e_err;
        logic [31:0] e_out;
        logic [9:0] idx;
        bit chk_out;
        int lat;
        idx = addr[9:0];
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        oob = addr >= 64'(DEPTH);
`else
        oob = 1'b0;
`endif
        e_err = (re == we) || oob;
        e_out = (e_err || we) ? 32'h0 : model[idx];
        chk_out = e_err || we || written[idx];
        ram_re = re; ram_we = we; ram_addr = addr; ram_wd = wd; ram_txs = 1'b1;
        tick();
        ram_re = 1'($urandom); ram_we = 1'($urandom); ram_addr = {$urandom, $urandom}; ram_wd = $urandom;
        lat = 0;
        while (!ram_txe && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, LAT);
        check("err", 32'(ram_err), 32'(e_err));
        if (chk_out) check("out", ram_out, e_out);
        if (!e_err && we) begin
            model[idx] = wd;
            written[idx] = 1'b1;
        end
        repeat (hold) begin
            tick();
            check("hold_txe", 32'(ram_txe), 32'd1);
            check("hold_err", 32'(ram_err), 32'(e_err));
            if (chk_out) check("hold_out", ram_out, e_out);
        end
        ram_txs = 1'b0;
        tick();
        check("txe_fall", 32'(ram_txe), 32'd0);
        check("err_clear", 32'(ram_err), 32'd0);
    endtask

    initial begin
        logic [63:0] a;
        for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
        repeat (2) tick();
        check("rst_txe", 32'(ram_txe), 32'd0);
        check("rst_err", 32'(ram_err), 32'd0);
        check("rst_out", ram_out, 32'd0);
        rst_n = 1'b1;
        tick();
        txn(1'b0, 1'b1, 64'd5, 32'hDEADBEEF, 0);
        txn(1'b1, 1'b0, 64'd5, 32'h0, 0);
        txn(1'b0, 1'b1, 64'd7, 32'h12345678, 1);
        txn(1'b1, 1'b1, 64'd7, 32'hCAFEF00D, 1);
        txn(1'b0, 1'b0, 64'd7, 32'hCAFEF00D, 0);
        txn(1'b1, 1'b0, 64'd7, 32'h0, 0);
        txn(1'b0, 1'b1, 64'd0, 32'h11111111, 0);
        txn(1'b0, 1'b1, 64'd1024, 32'hA5A5A5A5, 0);
        txn(1'b1, 1'b0, 64'd0, 32'h0, 0);
        txn(1'b0, 1'b1, 64'd9, 32'h99990009, 0);
        ram_re = 1'b0; ram_we = 1'b1; ram_addr = 64'd9; ram_wd = 32'h0BAD0BAD; ram_txs = 1'b1;
        tick();
        ram_txs = 1'b0;
        repeat (5) begin
            tick();
            check("abort_txe", 32'(ram_txe), 32'd0);
        end
        txn(1'b1, 1'b0, 64'd9, 32'h0, 0);
        txn(1'b0, 1'b1, 64'd11, 32'h0B0B0B0B, 0);
        txn(1'b1, 1'b0, 64'd5, 32'h0, 10);
        ram_re = 1'b0; ram_we = 1'b1; ram_addr = 64'd11; ram_wd = 32'hDEAD0011; ram_txs = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("busy_rst_txe", 32'(ram_txe), 32'd0);
        check("busy_rst_err", 32'(ram_err), 32'd0);
        check("busy_rst_out", ram_out, 32'd0);
        rst_n = 1'b1;
        ram_txs = 1'b0;
        tick();
        txn(1'b1, 1'b0, 64'd11, 32'h0, 0);
        for (int i = 0; i < 16; i++) txn(1'b0, 1'b1, 64'(i), $urandom, 0);
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 64'd1024 + 64'($urandom_range(0, 15)) : 64'($urandom_range(0, 15));
            txn(1'($urandom), 1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
